// File: rtl/trng_pkg.sv
// trng_pkg
//   Shared types and defaults for the TRNG collector slice.
//   - collector_state_t : collector FSM encoding (COLLECT, FAULT)
//   - DEF_WIDTH / DEF_DEPTH / DEF_RCT_LIMIT : default parameter values
//   - next_run() : saturating repetition-count step
package trng_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        FAULT   = 1'b1
    } collector_state_t;

    localparam int unsigned DEF_WIDTH     = 32;
    localparam int unsigned DEF_DEPTH     = 4;
    localparam int unsigned DEF_RCT_LIMIT = 16;

    // A run count of 0 means "no previous bit" (after reset or clear), so
    // the next accepted bit always starts a fresh run of 1.
    function automatic logic [7:0] next_run(input logic [7:0] run,
                                            input logic       same,
                                            input logic [7:0] limit);
        logic [7:0] result;
        if (run == 8'd0 || !same) begin
            result = 8'd1;
        end else if (run >= limit) begin
            result = limit;
        end else begin
            result = run + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/trng_fifo.sv
// trng_fifo
//   Synchronous show-ahead FIFO for completed TRNG words.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     push       : write wr_data (accepted when not full, or when popping)
//     wr_data    : word to write
//     pop        : remove head word (ignored when empty)
//     flush      : empty the FIFO; wins over push and pop
//     rd_data    : head word, forced to 0 when empty
//     full/empty : occupancy flags
//     count      : words held (0..DEPTH)
module trng_fifo
    import trng_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A push into a full FIFO still lands when the head leaves on the same
    // edge: the write slot is the one the pop frees.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Masking keeps the output at 0 out of reset without resetting memory.
    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/trng_collector.sv
// trng_collector
//   Packs accepted TRNG bits (MSB first) into WIDTH-bit words, buffers them
//   in a show-ahead FIFO and guards the stream with a repetition-count test.
//   Handshake: a word transfers on any rising edge where o_valid and i_ready
//   are both 1; o_valid never depends on i_ready and o_data is stable while
//   o_valid=1 and no transfer happens.
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset
//     i_valid      : bit strobe; i_bit sampled when 1
//     i_bit        : random bit
//     i_clear      : synchronous flush and error clear (highest priority)
//     i_ready      : consumer takes the head word
//     o_data       : head-of-FIFO word (0 when empty)
//     o_valid      : FIFO non-empty
//     o_count      : words held
//     o_overflow   : sticky, a completed word was dropped
//     o_health_err : sticky, repetition-count test tripped
//     o_state      : current FSM state, for observation
module trng_collector
    import trng_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned RCT_LIMIT = DEF_RCT_LIMIT,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned BIT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    input  logic             i_bit,
    input  logic             i_clear,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_count,
    output logic             o_overflow,
    output logic             o_health_err,
    output collector_state_t o_state
);

    collector_state_t state;
    collector_state_t state_next;

    logic [WIDTH-2:0] sreg;      // bits gathered so far; the newest bit joins at LSB
    logic [BIT_W-1:0] bit_cnt;
    logic [7:0]       run_cnt;
    logic             prev_bit;
    logic             overflow_q;

    logic             accept;
    logic [7:0]       run_new;
    logic             trip;
    logic             word_done;
    logic [WIDTH-1:0] word;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             drop;

    // ---------------- datapath decode ----------------
    always_comb begin
        accept    = (state == COLLECT) && i_valid && !i_clear;
        run_new   = next_run(run_cnt, i_bit == prev_bit, 8'(RCT_LIMIT));
        trip      = accept && (run_new == 8'(RCT_LIMIT));
        // A tripping bit never completes a word, even if it is the last one.
        word_done = accept && !trip && (bit_cnt == BIT_W'(WIDTH - 1));
        word      = {sreg, i_bit};
        pop       = !fifo_empty && i_ready;
        drop      = word_done && fifo_full && !pop;
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        if (i_clear) begin
            state_next = COLLECT;
        end else if (trip) begin
            state_next = FAULT;
        end
    end

    // ---------------- FSM: outputs ----------------
    // The error flag is sticky exactly as long as the FSM sits in FAULT.
    always_comb begin
        o_health_err = (state == FAULT);
        o_state      = state;
    end

    // ---------------- shift register, bit and run counters ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg     <= '0;
            bit_cnt  <= '0;
            run_cnt  <= '0;
            prev_bit <= 1'b0;
        end else if (i_clear) begin
            sreg     <= '0;
            bit_cnt  <= '0;
            run_cnt  <= '0;
            prev_bit <= 1'b0;
        end else if (accept) begin
            run_cnt  <= run_new;
            prev_bit <= i_bit;
            if (trip) begin
                sreg    <= '0;
                bit_cnt <= '0;
            end else begin
                sreg    <= word[WIDTH-2:0];
                bit_cnt <= word_done ? '0 : bit_cnt + BIT_W'(1);
            end
        end
    end

    // ---------------- sticky overflow ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (i_clear) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end
    end

    assign o_overflow = overflow_q;

    // ---------------- word FIFO ----------------
    trng_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (word_done),
        .wr_data (word),
        .pop     (pop),
        .flush   (i_clear),
        .rd_data (o_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (o_count)
    );

    assign o_valid = !fifo_empty;

endmodule

// File: tb/tb_trng_collector.sv
// tb_trng_collector
//   Directed bench for trng_collector with WIDTH=8, DEPTH=2, RCT_LIMIT=6.
//   Bits arrive one every 5th cycle; inputs change on the falling edge and
//   outputs are sampled on the falling edge.
module tb_trng_collector;
    import trng_pkg::*;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned DEPTH     = 2;
    localparam int unsigned RCT_LIMIT = 6;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             i_valid = 1'b0;
    logic             i_bit = 1'b0;
    logic             i_clear = 1'b0;
    logic             i_ready = 1'b0;
    logic [WIDTH-1:0] o_data;
    logic             o_valid;
    logic [1:0]       o_count;
    logic             o_overflow;
    logic             o_health_err;
    collector_state_t o_state;

    always #5 clk = ~clk;

    trng_collector #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RCT_LIMIT (RCT_LIMIT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_valid      (i_valid),
        .i_bit        (i_bit),
        .i_clear      (i_clear),
        .i_ready      (i_ready),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .o_count      (o_count),
        .o_overflow   (o_overflow),
        .o_health_err (o_health_err),
        .o_state      (o_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [WIDTH-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Four idle cycles, then one strobe cycle; returns on the falling edge
    // after the capturing rising edge.
    task automatic send_bit(input logic b, input logic ready_on_strobe);
        repeat (4) @(negedge clk);
        i_valid = 1'b1;
        i_bit   = b;
        i_ready = ready_on_strobe;
        @(negedge clk);
        i_valid = 1'b0;
        i_ready = 1'b0;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input logic ready_last);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            send_bit(w[i], (i == 0) ? ready_last : 1'b0);
        end
    endtask

    // Pop the head word and compare it to the oldest expected word.
    task automatic pop_check(input string name);
        logic [WIDTH-1:0] exp;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check({name, " valid"}, 32'(o_valid), 32'd1);
        check({name, " data"}, 32'(o_data), 32'(exp));
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        i_clear = 1'b1;
        @(negedge clk);
        i_clear = 1'b0;
        exp_q.delete();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic             clear_before;
        logic [WIDTH-1:0] word;
        logic             ready_last;
        logic [1:0]       exp_count;
        logic [WIDTH-1:0] exp_data;
        logic             exp_ovf;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input int i);
        if (vecs[i].clear_before) do_clear();
        send_word(vecs[i].word, vecs[i].ready_last);
        check($sformatf("vec%0d count", i), 32'(o_count), 32'(vecs[i].exp_count));
        check($sformatf("vec%0d valid", i), 32'(o_valid), 32'd1);
        check($sformatf("vec%0d head", i), 32'(o_data), 32'(vecs[i].exp_data));
        check($sformatf("vec%0d overflow", i), 32'(o_overflow), 32'(vecs[i].exp_ovf));
    endtask

    initial begin
        // Overflow: third word is dropped while the FIFO is full.
        vecs[0] = '{1'b1, 8'hA5, 1'b0, 2'd1, 8'hA5, 1'b0};
        vecs[1] = '{1'b0, 8'h5A, 1'b0, 2'd2, 8'hA5, 1'b0};
        vecs[2] = '{1'b0, 8'h3C, 1'b0, 2'd2, 8'hA5, 1'b1};
        // Full plus simultaneous pop: 8'h3C lands while 8'hA5 leaves.
        vecs[3] = '{1'b1, 8'hA5, 1'b0, 2'd1, 8'hA5, 1'b0};
        vecs[4] = '{1'b0, 8'h5A, 1'b0, 2'd2, 8'hA5, 1'b0};
        vecs[5] = '{1'b0, 8'h3C, 1'b1, 2'd2, 8'h5A, 1'b0};

        // Reset state.
        #12;
        check("reset data", 32'(o_data), 32'd0);
        check("reset valid", 32'(o_valid), 32'd0);
        check("reset count", 32'(o_count), 32'd0);
        check("reset overflow", 32'(o_overflow), 32'd0);
        check("reset health", 32'(o_health_err), 32'd0);
        check("reset state", 32'(o_state), 32'(COLLECT));
        @(negedge clk);
        rst_n = 1'b1;

        // Basic assembly: 1,0,1,1,0,0,1,0 -> 8'hB2.
        send_word(8'hB2, 1'b0);
        check("b2 valid", 32'(o_valid), 32'd1);
        check("b2 data", 32'(o_data), 32'hB2);
        check("b2 count", 32'(o_count), 32'd1);
        exp_q.push_back(8'hB2);
        pop_check("b2 pop");
        check("b2 count after pop", 32'(o_count), 32'd0);
        check("b2 valid after pop", 32'(o_valid), 32'd0);

        // Overflow.
        for (int i = 0; i < 3; i++) run_vec(i);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        pop_check("ovf pop1");
        pop_check("ovf pop2");
        check("ovf empty", 32'(o_valid), 32'd0);
        check("ovf sticky", 32'(o_overflow), 32'd1);

        // Asynchronous reset mid-word and mid-cycle.
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async data", 32'(o_data), 32'd0);
        check("async valid", 32'(o_valid), 32'd0);
        check("async count", 32'(o_count), 32'd0);
        check("async overflow", 32'(o_overflow), 32'd0);
        check("async health", 32'(o_health_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send_word(8'hA5, 1'b0);
        check("midword count", 32'(o_count), 32'd1);
        exp_q.push_back(8'hA5);
        pop_check("midword pop");
        check("midword empty", 32'(o_valid), 32'd0);

        // Full plus simultaneous pop.
        for (int i = 3; i < 6; i++) run_vec(i);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h3C);
        pop_check("simpop pop1");
        pop_check("simpop pop2");
        check("simpop empty", 32'(o_valid), 32'd0);

        // Health test: keep a word in the FIFO, then a run of six 1s.
        do_clear();
        send_word(8'hB2, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        check("health before trip", 32'(o_health_err), 32'd0);
        send_bit(1'b1, 1'b0);
        check("health trip", 32'(o_health_err), 32'd1);
        check("health state", 32'(o_state), 32'(FAULT));
        check("health count kept", 32'(o_count), 32'd1);
        check("health head kept", 32'(o_data), 32'hB2);
        send_word(8'h5A, 1'b0);
        check("fault ignores bits", 32'(o_count), 32'd1);
        check("fault sticky", 32'(o_health_err), 32'd1);
        do_clear();
        check("clear health", 32'(o_health_err), 32'd0);
        check("clear count", 32'(o_count), 32'd0);
        check("clear valid", 32'(o_valid), 32'd0);
        check("clear state", 32'(o_state), 32'(COLLECT));
        send_word(8'hB2, 1'b0);
        check("after clear count", 32'(o_count), 32'd1);
        exp_q.push_back(8'hB2);
        pop_check("after clear pop");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Runaway guard.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/trng_collector.md
# trng_collector

Consumer end of the TRNG bit stream. Samples `o_warbler` whenever `o_valid` pulses and packs the accepted bits into WIDTH-bit words. Words are buffered in a small FIFO and presented on a valid/ready port to the downstream consumer (bus slave or key loader). A repetition-count health test blocks output from a stuck source.

## Interface
- `WIDTH`, 32, bits per output word (≥2)
- `DEPTH`, 4, FIFO depth in words (power of 2, ≥2)
- `RCT_LIMIT`, 16, run of identical accepted bits that trips the health test (2..255)
- `clk`  in  1  clock; all logic on rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `i_valid`  in  1  bit strobe, driven by TRNG `o_valid`
- `i_bit`  in  1  random bit, driven by TRNG `o_warbler`; sampled only when `i_valid`=1
- `i_clear`  in  1  synchronous flush and error clear
- `i_ready`  in  1  consumer accepts the word on `o_data`
- `o_data`  out  WIDTH  head-of-FIFO word
- `o_valid`  out  1  FIFO non-empty
- `o_count`  out  $clog2(DEPTH+1)  words held
- `o_overflow`  out  1  sticky: a completed word was dropped
- `o_health_err`  out  1  sticky: repetition-count test tripped

## Operation
- FSM states: COLLECT (reset state) and FAULT.
- COLLECT, `i_valid`=1:
  - bit enters the shift register LSB, existing bits shift up, so the first bit ends in MSB;
  - bit counter increments;
  - on the WIDTH-th bit, the assembled word is pushed on the same edge and the bit counter returns to 0.
- Run counter:
  - accepted bit equal to the previous accepted bit → run+1, saturating at RCT_LIMIT;
  - otherwise run = 1;
  - runs span word boundaries;
  - first bit after reset or clear → run = 1.
- Run reaching RCT_LIMIT:
  - → FAULT, `o_health_err`=1;
  - the partial word is discarded, and so is the word that bit would have completed;
  - FIFO contents are kept and remain readable.
- FAULT: `i_valid` ignored; exit only via `i_clear` or reset.
- Push with FIFO full:
  - with `i_ready`=0: word dropped, `o_overflow`=1, FIFO unchanged;
  - with a simultaneous pop (`o_valid`&`i_ready`): push succeeds, count unchanged, no overflow.
- Pop = `o_valid`&`i_ready`. FIFO is show-ahead; `o_data` is don't-care when `o_valid`=0.
- `i_clear` has priority over everything on its edge:
  - FIFO emptied; shift register, bit counter and run counter zeroed;
  - both stickies cleared; → COLLECT;
  - a concurrent `i_valid` bit is discarded and a concurrent pop is void.
- Async reset mid-word: all state lost; the next accepted bit starts a fresh word.

## Timing
- Reset values:
  - `o_data`=0, `o_valid`=0, `o_count`=0, `o_overflow`=0, `o_health_err`=0;
  - FSM=COLLECT, counters 0.
- Push latency: WIDTH-th bit captured at edge N → `o_valid`=1 and `o_data` valid after edge N (one cycle after the bit is presented).
- Pop at edge M → next word (or `o_valid`=0) after edge M. Sustained throughput is 1 word/cycle.
- `o_health_err` rises after the edge capturing the RCT_LIMIT-th identical bit.
- `o_overflow` rises after the edge of the dropped push.
- `o_count` is updated on the same edge as the push or pop.
- No combinational path from inputs to outputs.

## Structure
- Package `trng_pkg`:
  - `collector_state_t` enum {COLLECT, FAULT};
  - default constants for WIDTH, DEPTH, RCT_LIMIT.
- Sub-module `trng_fifo`: synchronous show-ahead FIFO, parameterised on WIDTH and DEPTH, with push, pop, flush, full, empty and count.
- `trng_collector` holds the FSM, shift register, bit counter and run counter.

## Test plan
Bench parameters: WIDTH=8, DEPTH=2, RCT_LIMIT=6; `i_valid` pulses every 5th cycle.
- Reset: `rst_n`=0 mid-cycle → all outputs 0 immediately, with no clock edge needed.
- Bits 1,0,1,1,0,0,1,0 with `i_ready`=0:
  - `o_valid`=1 and `o_data`=8'hB2 one cycle after the 8th bit;
  - `o_count`=1;
  - `i_ready`=1 for one cycle → `o_count`=0, `o_valid`=0.
- Overflow, `i_ready`=0, words 8'hA5, 8'h5A, 8'h3C:
  - `o_count`=2 after two words;
  - third completion sets `o_overflow`=1;
  - pops return 8'hA5 then 8'h5A; 8'h3C is lost.
- Full plus simultaneous pop:
  - fill with 8'hA5, 8'h5A; hold `i_ready`=1 on the edge completing 8'h3C;
  - `o_overflow`=0, `o_count`=2;
  - pops return 8'h5A, 8'h3C.
- Health:
  - six consecutive 1s → `o_health_err`=1 after the 6th edge, no push;
  - further bits ignored;
  - `i_clear` → error 0, `o_count`=0, then 8'hB2 assembles normally.
- Reset mid-word: 4 bits accepted, pulse `rst_n` low → 8 new bits 8'hA5 yield exactly 8'hA5.
